// File: rtl/acl_pkg.sv
// Shared encodings and default tuning constants for the tilt-to-volume controller.
// The FSM state, the exported tilt code and the nominal thresholds live here.
package acl_pkg;

  localparam int ACL_DATA_W = 8;
  localparam int TH_ON_DEF  = 32;
  localparam int TH_OFF_DEF = 16;
  localparam int DWELL_DEF  = 8;
  localparam int REPEAT_DEF = 16;
  localparam int CNT_W_DEF  = 5;

  typedef enum logic [1:0] {
    TILT_FLAT = 2'b00,
    TILT_POS  = 2'b01,
    TILT_NEG  = 2'b10
  } tilt_e;

  typedef enum logic [2:0] {
    ST_FLAT,
    ST_ARM_POS,
    ST_HELD_POS,
    ST_ARM_NEG,
    ST_HELD_NEG
  } fsm_e;

  function automatic tilt_e tilt_of(input fsm_e s);
    case (s)
      ST_ARM_POS, ST_HELD_POS: return TILT_POS;
      ST_ARM_NEG, ST_HELD_NEG: return TILT_NEG;
      default:                 return TILT_FLAT;
    endcase
  endfunction

endpackage

// File: rtl/acl_mavg4.sv
// Four-sample moving average of a signed stream; result and its valid strobe
// are registered together one cycle after the input strobe.
module acl_mavg4
  import acl_pkg::*;
#(
  parameter int DATA_W = ACL_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] d_i,
  input  logic                     vld_i,
  output logic signed [DATA_W-1:0] avg_o,
  output logic                     avg_vld_o
);

  localparam int SUM_W = DATA_W + 2;

  // Only the three most recent samples are kept: the fourth is the incoming one.
  logic signed [DATA_W-1:0] win_p1_q [3];
  logic signed [DATA_W-1:0] avg_p1_q;
  logic                     vld_p1_q;
  logic signed [SUM_W-1:0]  sum_p0;

  function automatic logic signed [SUM_W-1:0] sext(input logic signed [DATA_W-1:0] v);
    return {{2{v[DATA_W-1]}}, v};
  endfunction

  function automatic logic signed [DATA_W-1:0] avg_floor(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] q;
    q = s >>> 2;
    return q[DATA_W-1:0];
  endfunction

  always_comb begin
    sum_p0 = sext(d_i) + sext(win_p1_q[0]) + sext(win_p1_q[1]) + sext(win_p1_q[2]);
  end

  // ---- stage p0 -> p1: window shift and average
  always_ff @(posedge clk) begin
    if (rst) begin
      win_p1_q <= '{default: '0};
      avg_p1_q <= '0;
      vld_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_i;
      if (vld_i) begin
        win_p1_q[2] <= win_p1_q[1];
        win_p1_q[1] <= win_p1_q[0];
        win_p1_q[0] <= d_i;
        avg_p1_q    <= avg_floor(sum_p0);
      end
    end
  end

  assign avg_o     = avg_p1_q;
  assign avg_vld_o = vld_p1_q;

endmodule

// File: rtl/acl_tilt_ctrl.sv
// Tilt classifier: hysteresis plus dwell on the averaged Z sample, producing
// one-cycle vol_up / vol_down pulses with auto-repeat while the tilt is held.
module acl_tilt_ctrl
  import acl_pkg::*;
#(
  parameter int TH_ON  = TH_ON_DEF,
  parameter int TH_OFF = TH_OFF_DEF,
  parameter int DWELL  = DWELL_DEF,
  parameter int REPEAT = REPEAT_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic signed [7:0] z_data,
  input  logic              z_valid,
  input  logic              en,
  output logic signed [7:0] z_avg,
  output logic [1:0]        tilt_state,
  output logic              vol_up,
  output logic              vol_down
);

  logic signed [7:0] avg_p1;
  logic              vld_p1;
  int                avg_s;

  fsm_e             state_q, state_d;
  tilt_e            tilt_q, tilt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             up_q, up_d, dn_q, dn_d;

  acl_mavg4 #(.DATA_W(8)) u_mavg (
    .clk      (clk),
    .rst      (rst),
    .d_i      (z_data),
    .vld_i    (z_valid),
    .avg_o    (avg_p1),
    .avg_vld_o(vld_p1)
  );

  assign avg_s = int'(avg_p1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    if (!en) begin
      state_d = ST_FLAT;
      cnt_d   = '0;
    end else if (vld_p1) begin
      case (state_q)
        ST_FLAT: begin
          // A single-evaluation dwell fires on the arming evaluation itself.
          if (avg_s >= TH_ON) begin
            if (DWELL == 1) begin
              state_d = ST_HELD_POS;
              up_d    = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = ST_ARM_POS;
              cnt_d   = CNT_W'(1);
            end
          end else if (avg_s <= -TH_ON) begin
            if (DWELL == 1) begin
              state_d = ST_HELD_NEG;
              dn_d    = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = ST_ARM_NEG;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_ARM_POS, ST_HELD_POS: begin
          if (avg_s <= TH_OFF) begin
            state_d = ST_FLAT;
            cnt_d   = '0;
          end else if ((state_q == ST_ARM_POS  && cnt_q == CNT_W'(DWELL - 1)) ||
                       (state_q == ST_HELD_POS && cnt_q == CNT_W'(REPEAT - 1))) begin
            state_d = ST_HELD_POS;
            up_d    = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_ARM_NEG, ST_HELD_NEG: begin
          if (avg_s >= -TH_OFF) begin
            state_d = ST_FLAT;
            cnt_d   = '0;
          end else if ((state_q == ST_ARM_NEG  && cnt_q == CNT_W'(DWELL - 1)) ||
                       (state_q == ST_HELD_NEG && cnt_q == CNT_W'(REPEAT - 1))) begin
            state_d = ST_HELD_NEG;
            dn_d    = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_FLAT;
          cnt_d   = '0;
        end
      endcase
    end
    tilt_d = tilt_of(state_d);
  end

  // ---- stage p1 -> p2: classification and pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FLAT;
      tilt_q  <= TILT_FLAT;
      cnt_q   <= '0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tilt_q  <= tilt_d;
      cnt_q   <= cnt_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
    end
  end

  assign z_avg      = avg_p1;
  assign tilt_state = tilt_q;
  assign vol_up     = up_q;
  assign vol_down   = dn_q;

endmodule

// File: tb/tb_acl_tilt_ctrl.sv
// Directed bench for acl_tilt_ctrl: hand-computed averages, tilt codes and
// pulse timing around dwell, repeat, hysteresis, enable and reset.
module tb_acl_tilt_ctrl;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic signed [7:0] z_data = '0;
  logic              z_valid = 1'b0;
  logic              en = 1'b1;
  logic signed [7:0] z_avg;
  logic [1:0]        tilt_state;
  logic              vol_up, vol_down;

  int vectors = 0;
  int miscompares = 0;
  int up_cnt = 0, dn_cnt = 0, both_cnt = 0;
  logic signed [7:0] last_avg;
  logic              last_up, last_dn;

  acl_tilt_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .z_data    (z_data),
    .z_valid   (z_valid),
    .en        (en),
    .z_avg     (z_avg),
    .tilt_state(tilt_state),
    .vol_up    (vol_up),
    .vol_down  (vol_down)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and tally any pulse seen there.
  task automatic tick();
    @(negedge clk);
    if (vol_up)             up_cnt++;
    if (vol_down)           dn_cnt++;
    if (vol_up && vol_down) both_cnt++;
  endtask

  // One sample: strobe, average visible one cycle later, FSM result one more cycle later.
  task automatic send(input logic signed [7:0] z);
    tick();
    z_data  = z;
    z_valid = 1'b1;
    tick();
    z_valid = 1'b0;
    last_avg = z_avg;
    tick();
    last_up = vol_up;
    last_dn = vol_down;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    up_cnt = 0;
    dn_cnt = 0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_avg", 32'(z_avg), 0);
    chk("rst_tilt", 32'(tilt_state), 0);
    chk("rst_up", 32'(vol_up), 0);
    chk("rst_dn", 32'(vol_down), 0);
    rst = 1'b0;

    // 1: z = 40 ramps the average, arms on the 4th, first vol_up on the 11th
    send(8'sd40); chk("t1_avg1", 32'(last_avg), 10);
    send(8'sd40); chk("t1_avg2", 32'(last_avg), 20);
    send(8'sd40); chk("t1_avg3", 32'(last_avg), 30);
    chk("t1_tilt3", 32'(tilt_state), 0);
    send(8'sd40); chk("t1_avg4", 32'(last_avg), 40);
    chk("t1_tilt4", 32'(tilt_state), 1);
    for (int i = 5; i <= 10; i++) send(8'sd40);
    chk("t1_nopulse_before", up_cnt, 0);
    send(8'sd40);
    chk("t1_pulse11", 32'(last_up), 1);
    chk("t1_upcnt", up_cnt, 1);
    chk("t1_tilt", 32'(tilt_state), 1);

    // 2: auto-repeat on the 16th held evaluation
    for (int i = 1; i <= 15; i++) send(8'sd40);
    chk("t2_no_early_repeat", up_cnt, 1);
    send(8'sd40);
    chk("t2_repeat16", 32'(last_up), 1);
    chk("t2_upcnt", up_cnt, 2);
    chk("t2_no_down", dn_cnt, 0);

    // 4: hysteresis, average settles at 24 and pulses continue, exits at exactly 16
    send(8'sd24); chk("t4_avg36", 32'(last_avg), 36);
    send(8'sd24); chk("t4_avg32", 32'(last_avg), 32);
    send(8'sd24); chk("t4_avg28", 32'(last_avg), 28);
    send(8'sd24); chk("t4_avg24", 32'(last_avg), 24);
    chk("t4_still_pos", 32'(tilt_state), 1);
    for (int i = 1; i <= 11; i++) send(8'sd24);
    chk("t4_no_early", up_cnt, 2);
    send(8'sd24);
    chk("t4_repeat_at24", 32'(last_up), 1);
    chk("t4_upcnt", up_cnt, 3);
    send(8'sd16); chk("t4_avg22", 32'(last_avg), 22);
    send(8'sd16); chk("t4_avg20", 32'(last_avg), 20);
    send(8'sd16); chk("t4_avg18", 32'(last_avg), 18);
    chk("t4_pos_at18", 32'(tilt_state), 1);
    send(8'sd16); chk("t4_avg16", 32'(last_avg), 16);
    chk("t4_flat_at16", 32'(tilt_state), 0);
    chk("t4_upcnt_exit", up_cnt, 3);

    // 3: negative tilt, release through FLAT, full re-dwell
    send(-8'sd64); chk("t3_avg_m4", 32'(last_avg), -4);
    send(-8'sd64); chk("t3_avg_m24", 32'(last_avg), -24);
    send(-8'sd64); chk("t3_avg_m44", 32'(last_avg), -44);
    chk("t3_tilt_neg", 32'(tilt_state), 2);
    for (int i = 4; i <= 9; i++) send(-8'sd64);
    chk("t3_no_early_down", dn_cnt, 0);
    send(-8'sd64);
    chk("t3_down", 32'(last_dn), 1);
    send(8'sd20); chk("t3_avg_m43", 32'(last_avg), -43);
    send(8'sd20); chk("t3_avg_m22", 32'(last_avg), -22);
    chk("t3_neg_at_m22", 32'(tilt_state), 2);
    send(8'sd20); chk("t3_avg_m1", 32'(last_avg), -1);
    chk("t3_flat", 32'(tilt_state), 0);
    chk("t3_dn_after_release", dn_cnt, 1);
    send(-8'sd64);
    send(-8'sd64); chk("t3_flat_m22", 32'(tilt_state), 0);
    send(-8'sd64); chk("t3_rearm", 32'(tilt_state), 2);
    for (int i = 4; i <= 9; i++) send(-8'sd64);
    chk("t3_redwell_no_early", dn_cnt, 1);
    send(-8'sd64);
    chk("t3_redwell_down", 32'(last_dn), 1);
    chk("t3_upcnt_unchanged", up_cnt, 3);

    // 5: back-to-back -128 samples, no wrap, vol_down after 8 evaluations
    do_reset();
    tick();
    z_data  = -8'sd128;
    z_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("t5_avg%0d", i), 32'(z_avg), (i >= 4) ? -128 : -32 * i);
      chk($sformatf("t5_dn%0d", i), 32'(vol_down), (i == 9) ? 1 : 0);
      if (i == 10) z_valid = 1'b0;
    end
    tick();
    chk("t5_dncnt", dn_cnt, 1);

    // 6: arm exactly at TH_ON, drop en while held, exit exactly at TH_OFF, reset mid-arm
    do_reset();
    send(8'sd64); chk("t6_avg16", 32'(last_avg), 16);
    chk("t6_flat", 32'(tilt_state), 0);
    send(8'sd64); chk("t6_avg32", 32'(last_avg), 32);
    chk("t6_arm_at_th_on", 32'(tilt_state), 1);
    for (int i = 3; i <= 8; i++) send(8'sd64);
    send(8'sd64);
    chk("t6_up9", 32'(last_up), 1);
    tick();
    en = 1'b0;
    tick();
    chk("t6_en_tilt", 32'(tilt_state), 0);
    chk("t6_en_up", 32'(vol_up), 0);
    send(8'sd64);
    chk("t6_en_avg_runs", 32'(last_avg), 64);
    chk("t6_en_blocked", 32'(last_up), 0);
    chk("t6_en_still_flat", 32'(tilt_state), 0);
    en = 1'b1;
    send(8'sd64);
    chk("t6_rearm_pos", 32'(tilt_state), 1);
    send(-8'sd128); chk("t6_avg_exit16", 32'(last_avg), 16);
    chk("t6_exit_at_th_off", 32'(tilt_state), 0);
    send(-8'sd128); chk("t6_avg_m32", 32'(last_avg), -32);
    chk("t6_arm_neg", 32'(tilt_state), 2);
    send(-8'sd128); chk("t6_avg_m80", 32'(last_avg), -80);
    tick();
    rst = 1'b1;
    tick();
    chk("t6_rst_avg", 32'(z_avg), 0);
    chk("t6_rst_tilt", 32'(tilt_state), 0);
    chk("t6_rst_up", 32'(vol_up), 0);
    chk("t6_rst_dn", 32'(vol_down), 0);
    rst = 1'b0;
    tick();
    chk("t6_post_rst_dn", 32'(vol_down), 0);
    up_cnt = 0;
    dn_cnt = 0;
    send(-8'sd128); chk("t6_re_avg_m32", 32'(last_avg), -32);
    chk("t6_re_arm", 32'(tilt_state), 2);
    for (int i = 2; i <= 7; i++) send(-8'sd128);
    chk("t6_re_no_early", dn_cnt, 0);
    send(-8'sd128);
    chk("t6_re_down8", 32'(last_dn), 1);
    send(8'sd1);
    chk("t6_floor_m96", 32'(last_avg), -96);

    chk("never_both", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
